// File: rtl/sm4_key_sched_ctrl_if.sv
// Bus bundle between the SM4 key-schedule controller and its host/round engine:
// start/master key in, round-key stream and register-file read port out.
interface sm4_key_sched_ctrl_if;
  logic         start;
  logic [127:0] mk;
  logic         busy;
  logic         done;
  logic         keys_ready;
  logic         rk_valid;
  logic [4:0]   rk_idx;
  logic [31:0]  rk_data;
  logic [4:0]   rd_addr;
  logic [31:0]  rd_data;

  modport slave (
    input  start, mk, rd_addr,
    output busy, done, keys_ready, rk_valid, rk_idx, rk_data, rd_data
  );

  modport master (
    output start, mk, rd_addr,
    input  busy, done, keys_ready, rk_valid, rk_idx, rk_data, rd_data
  );
endinterface

// File: rtl/sm4_key_sched_ctrl.sv
// SM4 key expansion sequencer: one round per clock, external CK table and S-box,
// 32-entry round-key file with combinational read and a per-key output stream.
//
//  state  | meaning
//  S_IDLE | waiting for start; no file writes, round_cnt held at 0
//  S_RUN  | one key-schedule round per clock, cnt = round being computed
module sm4_key_sched_ctrl #(
  parameter int NROUNDS = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  sm4_key_sched_ctrl_if.slave         bus,
  output logic [4:0]                  round_cnt_o,
  input  logic [31:0]                 cki_i,
  output logic [31:0]                 sbox_in_o,
  input  logic [31:0]                 sbox_out_i
);

  localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;
  localparam logic [4:0]   LAST_CNT = 5'(NROUNDS - 1);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e      state_q, state_d;
  logic [31:0] k0_q, k1_q, k2_q, k3_q;
  logic [31:0] k0_d, k1_d, k2_d, k3_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        keys_ready_q, keys_ready_d;
  logic        rk_valid_q, rk_valid_d;
  logic [4:0]  rk_idx_q, rk_idx_d;
  logic [31:0] rk_data_q, rk_data_d;
  logic [31:0] file_q [32];
  logic        file_we;
  logic [31:0] b, rk;

  // L' linear transform of the key schedule applied to the S-box output
  assign b  = sbox_out_i;
  assign rk = k0_q ^ b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};

  assign sbox_in_o   = k1_q ^ k2_q ^ k3_q ^ cki_i;
  assign round_cnt_o = (state_q == S_RUN) ? cnt_q : 5'd0;

  always_comb begin
    state_d      = state_q;
    k0_d         = k0_q;
    k1_d         = k1_q;
    k2_d         = k2_q;
    k3_d         = k3_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    keys_ready_d = keys_ready_q;
    rk_valid_d   = 1'b0;
    rk_idx_d     = rk_idx_q;
    rk_data_d    = rk_data_q;
    file_we      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          k0_d         = bus.mk[127:96] ^ FK[127:96];
          k1_d         = bus.mk[95:64]  ^ FK[95:64];
          k2_d         = bus.mk[63:32]  ^ FK[63:32];
          k3_d         = bus.mk[31:0]   ^ FK[31:0];
          cnt_d        = 5'd0;
          busy_d       = 1'b1;
          keys_ready_d = 1'b0;
          state_d      = S_RUN;
        end
      end
      S_RUN: begin
        k0_d       = k1_q;
        k1_d       = k2_q;
        k2_d       = k3_q;
        k3_d       = rk;
        file_we    = 1'b1;
        rk_valid_d = 1'b1;
        rk_idx_d   = cnt_q;
        rk_data_d  = rk;
        cnt_d      = cnt_q + 5'd1;
        if (cnt_q == LAST_CNT) begin
          state_d      = S_IDLE;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          keys_ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      k0_q         <= '0;
      k1_q         <= '0;
      k2_q         <= '0;
      k3_q         <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      keys_ready_q <= 1'b0;
      rk_valid_q   <= 1'b0;
      rk_idx_q     <= '0;
      rk_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      k0_q         <= k0_d;
      k1_q         <= k1_d;
      k2_q         <= k2_d;
      k3_q         <= k3_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      keys_ready_q <= keys_ready_d;
      rk_valid_q   <= rk_valid_d;
      rk_idx_q     <= rk_idx_d;
      rk_data_q    <= rk_data_d;
    end
  end

  // Round-key file; a reset wipes any partial key set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) file_q[i] <= '0;
    end else if (file_we) begin
      file_q[cnt_q] <= rk;
    end
  end

  assign bus.rd_data    = file_q[bus.rd_addr];
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.keys_ready = keys_ready_q;
  assign bus.rk_valid   = rk_valid_q;
  assign bus.rk_idx     = rk_idx_q;
  assign bus.rk_data    = rk_data_q;

endmodule

// File: tb/tb_sm4_key_sched_ctrl.sv
// Self-checking bench for sm4_key_sched_ctrl: provides the CK table and S-box,
// compares the key stream and register file against an independent key-schedule model.
module tb_sm4_key_sched_ctrl;

  localparam logic [2047:0] SBOX_TBL = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };
  localparam logic [127:0] FK_M  = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;
  localparam logic [127:0] MK_STD = 128'h0123456789ABCDEFFEDCBA9876543210;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  round_cnt;
  logic [31:0] cki, sbox_in, sbox_out;

  sm4_key_sched_ctrl_if bus ();

  sm4_key_sched_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .round_cnt_o (round_cnt),
    .cki_i       (cki),
    .sbox_in_o   (sbox_in),
    .sbox_out_i  (sbox_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX_TBL[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    return {sb(a[31:24]), sb(a[23:16]), sb(a[15:8]), sb(a[7:0])};
  endfunction

  function automatic logic [31:0] ck_of(input logic [4:0] i);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[31-8*j -: 8] = 8'((4*int'(i) + j) * 7);
    return r;
  endfunction

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  always_comb cki = ck_of(round_cnt);
  always_comb sbox_out = tau(sbox_in);

  logic [31:0] gold [32];
  logic [31:0] fmodel [32];
  logic [31:0] stream [32];
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;
  rd_vec_t vecs [3];

  task automatic compute_gold(input logic [127:0] mk);
    logic [31:0] k [4];
    logic [31:0] b, r;
    for (int i = 0; i < 4; i++) k[i] = mk[127-32*i -: 32] ^ FK_M[127-32*i -: 32];
    for (int i = 0; i < 32; i++) begin
      b = tau(k[1] ^ k[2] ^ k[3] ^ ck_of(5'(i)));
      r = k[0] ^ b ^ rol(b, 13) ^ rol(b, 23);
      gold[i] = r;
      k[0] = k[1]; k[1] = k[2]; k[2] = k[3]; k[3] = r;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts at the current (pre-edge) time; returns in the cycle where done should be high.
  task automatic do_run(input logic [127:0] mk, input bit toggle, input bit poke);
    compute_gold(mk);
    bus.mk = mk;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    chk("keys_ready_drop", 32'(bus.keys_ready), 32'd0);
    chk("no_valid_e0", 32'(bus.rk_valid), 32'd0);
    for (int c = 1; c <= 32; c++) begin
      chk($sformatf("round_cnt_%0d", c-1), 32'(round_cnt), 32'(c-1));
      bus.rd_addr = 5'(c-1);
      #1;
      chk($sformatf("rd_old_%0d", c-1), bus.rd_data, fmodel[c-1]);
      if (toggle) bus.mk = ~bus.mk ^ {4{$urandom}};
      if (poke && (c-1 == 5 || c-1 == 31)) begin
        bus.start = 1'b1;
        bus.mk = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
      bus.start = 1'b0;
      chk($sformatf("rk_valid_%0d", c-1), 32'(bus.rk_valid), 32'd1);
      chk($sformatf("rk_idx_%0d", c-1), 32'(bus.rk_idx), 32'(c-1));
      chk($sformatf("rk_data_%0d", c-1), bus.rk_data, gold[c-1]);
      stream[c-1] = bus.rk_data;
      chk($sformatf("done_%0d", c), 32'(bus.done), (c == 32) ? 32'd1 : 32'd0);
    end
    chk("busy_end", 32'(bus.busy), 32'd0);
    chk("keys_ready_end", 32'(bus.keys_ready), 32'd1);
    for (int i = 0; i < 32; i++) fmodel[i] = gold[i];
  endtask

  initial begin
    vecs[0] = '{addr: 5'd0,  exp: 32'hF12186F9};
    vecs[1] = '{addr: 5'd1,  exp: 32'h41662B61};
    vecs[2] = '{addr: 5'd31, exp: 32'h9124A012};
    for (int i = 0; i < 32; i++) fmodel[i] = '0;
    bus.start = 1'b0;
    bus.mk = '0;
    bus.rd_addr = '0;
    #12;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_keys_ready", 32'(bus.keys_ready), 32'd0);
    chk("rst_rk_valid", 32'(bus.rk_valid), 32'd0);
    chk("rst_rd_data", bus.rd_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_round_cnt", 32'(round_cnt), 32'd0);

    // Standard vector, then back-to-back starts on each done cycle
    do_run(MK_STD, 1'b0, 1'b0);
    do_run('0, 1'b0, 1'b1);
    do_run(MK_STD, 1'b1, 1'b0);
    tick();
    chk("idle_done", 32'(bus.done), 32'd0);
    chk("idle_rk_valid", 32'(bus.rk_valid), 32'd0);
    chk("idle_round_cnt2", 32'(round_cnt), 32'd0);
    foreach (vecs[v]) begin
      bus.rd_addr = vecs[v].addr;
      #1;
      chk($sformatf("kat_rk%0d", vecs[v].addr), bus.rd_data, vecs[v].exp);
    end
    for (int i = 0; i < 32; i++) begin
      bus.rd_addr = 5'(i);
      #0.1;
      chk($sformatf("file_vs_stream_%0d", i), bus.rd_data, stream[i]);
    end

    // Reset in the middle of a run
    @(negedge clk);
    bus.mk = MK_STD;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_keys_ready", 32'(bus.keys_ready), 32'd0);
    chk("midrst_rk_valid", 32'(bus.rk_valid), 32'd0);
    for (int i = 0; i < 32; i++) begin
      bus.rd_addr = 5'(i);
      #0.1;
      chk($sformatf("midrst_rd_%0d", i), bus.rd_data, 32'd0);
      fmodel[i] = '0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_run('0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 32; i++) begin
      bus.rd_addr = 5'(i);
      #0.1;
      chk($sformatf("final_file_%0d", i), bus.rd_data, gold[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
